// File: rtl/maxpool1_2x2.sv
// Purpose : 2x2 stride-2 max pooling of a 24x24 Float8 map into 12x12, optional ReLU.
// Latency : start accepted at edge E0, one window per cycle, window 143 written at E144, done high the following cycle.
// Backpres: none; start is only accepted in IDLE and ignored while busy, input map is snapshotted at accept.
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   start        - pool request, honoured only when idle
//   tensor_in    - 24x24 Float8 map, element (r,c) at [(r*24+c)*8 +: 8]
//   in_overflow  - upstream overflow flag, captured with the map
//   busy         - high from accept until the done cycle inclusive
//   done         - single-cycle completion pulse
//   tensor_out   - 12x12 pooled map, element (i,j) at [(i*12+j)*8 +: 8]
//   overflow     - in_overflow as captured for the current/last pass

module maxpool1_2x2 #(
  parameter bit RELU_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [24*24*8-1:0]  tensor_in,
  input  logic                in_overflow,
  output logic                busy,
  output logic                done,
  output logic [12*12*8-1:0]  tensor_out,
  output logic                overflow
);

  localparam int IN_DIM   = 24;
  localparam int OUT_DIM  = 12;
  localparam int EW       = 8;
  localparam int IN_BITS  = IN_DIM * IN_DIM * EW;
  localparam int OUT_BITS = OUT_DIM * OUT_DIM * EW;
  localparam int N_WIN    = OUT_DIM * OUT_DIM;

  // One input row in bits; the lower pair of a window sits one row below the upper pair.
  localparam logic [12:0] ROW_BITS = 13'(IN_DIM * EW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 accept;

  logic [IN_BITS-1:0]   buf_q;
  logic [OUT_BITS-1:0]  tensor_out_q;
  logic                 overflow_q;

  // Window position kept both as (row,col) for input addressing and as a
  // flat index k for the output slot, avoiding a divide/multiply per cycle.
  logic [3:0]           win_row_q;
  logic [3:0]           win_col_q;
  logic [7:0]           win_idx_q;
  logic                 last_win;

  logic [9:0]           el_base;
  logic [12:0]          bit_base;
  logic [7:0]           e00, e01, e10, e11;
  logic [7:0]           max_top, max_bot, win_max, pooled;

  // Strict "a greater than b" for sign-magnitude Float8. +0 and -0 are equal,
  // so a non-negative value only beats a negative one when not both are zero.
  function automatic logic fp8_gt(input logic [7:0] a, input logic [7:0] b);
    logic res;
    res = 1'b0;
    case ({a[7], b[7]})
      2'b00:   res = (a[6:0] > b[6:0]);
      2'b11:   res = (a[6:0] < b[6:0]);
      2'b01:   res = !((a[6:0] == 7'd0) && (b[6:0] == 7'd0));
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign last_win = (win_idx_q == 8'(N_WIN - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_win) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Input snapshot. Contents are irrelevant until the first accept, so no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q <= tensor_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Window fetch and reduction
  // ---------------------------------------------------------------------------
  always_comb begin
    // Top-left element index: (2i)*24 + 2j
    el_base  = 10'(win_row_q) * 10'd48 + 10'(win_col_q) * 10'd2;
    bit_base = {el_base, 3'b000};
    e00      = buf_q[bit_base                      +: EW];
    e01      = buf_q[bit_base + 13'(EW)            +: EW];
    e10      = buf_q[bit_base + ROW_BITS           +: EW];
    e11      = buf_q[bit_base + ROW_BITS + 13'(EW) +: EW];
  end

  // Earlier operand wins every tie, so the tree picks the first maximum in
  // scan order and keeps its exact bit pattern (a -0 can survive).
  always_comb begin
    max_top = fp8_gt(e01, e00) ? e01 : e00;
    max_bot = fp8_gt(e11, e10) ? e11 : e10;
    win_max = fp8_gt(max_bot, max_top) ? max_bot : max_top;
    pooled  = (RELU_EN && win_max[7]) ? 8'h00 : win_max;
  end

  // ---------------------------------------------------------------------------
  // Output slots, overflow capture and window stepping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tensor_out_q <= '0;
      overflow_q   <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_idx_q    <= '0;
    end else if (accept) begin
      overflow_q   <= in_overflow;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_idx_q    <= '0;
    end else if (state_q == S_RUN) begin
      tensor_out_q[{win_idx_q, 3'b000} +: EW] <= pooled;
      if (last_win) begin
        win_row_q <= '0;
        win_col_q <= '0;
        win_idx_q <= '0;
      end else begin
        win_idx_q <= win_idx_q + 8'd1;
        if (win_col_q == 4'(OUT_DIM - 1)) begin
          win_col_q <= '0;
          win_row_q <= win_row_q + 4'd1;
        end else begin
          win_col_q <= win_col_q + 4'd1;
        end
      end
    end
  end

  assign tensor_out = tensor_out_q;
  assign overflow   = overflow_q;

endmodule
